// File: rtl/flex_xy_scan.sv
// Raster scan of (x, y) work coordinates over a programmable region.
// It uses a programmable horizontal stride and valid/ready output handshaking.
module flex_xy_scan #(
    parameter int unsigned NUM_X_BITS = 10,
    parameter int unsigned NUM_Y_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic [NUM_X_BITS-1:0] x_max,
    input  logic [NUM_Y_BITS-1:0] y_max,
    input  logic [NUM_X_BITS-1:0] x_step,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [NUM_X_BITS-1:0] x_out,
    output logic [NUM_Y_BITS-1:0] y_out,
    output logic                  row_last,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned XW = NUM_X_BITS + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [NUM_X_BITS-1:0] x_max_l;
    logic [NUM_Y_BITS-1:0] y_max_l;
    logic [NUM_X_BITS-1:0] step_l;
    logic [XW-1:0]         nx;

    // One extra bit on the next-x sum so x_max at all-ones still ends the row.
    assign nx       = XW'(x_out) + XW'(step_l);
    assign row_last = out_valid && (nx > XW'(x_max_l));
    assign last     = row_last && (y_out == y_max_l);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            x_max_l   <= '0;
            y_max_l   <= '0;
            step_l    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        x_max_l   <= x_max;
                        y_max_l   <= y_max;
                        step_l    <= (x_step == '0) ? NUM_X_BITS'(1) : x_step;
                        x_out     <= '0;
                        y_out     <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        if (!row_last) begin
                            x_out <= nx[NUM_X_BITS-1:0];
                        end else if (!last) begin
                            x_out <= '0;
                            y_out <= y_out + NUM_Y_BITS'(1);
                        end else begin
                            x_out     <= '0;
                            y_out     <= '0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flex_xy_scan.sv
// Directed self-checking bench for flex_xy_scan.
// It checks raster order, stride, backpressure, abort, overflow and start/reset handling.
module tb_flex_xy_scan;

    logic       clk = 1'b0;
    logic       rst, clear, start, out_ready;
    logic [9:0] x_max, x_step, y_max;
    logic       out_valid, row_last, last, busy, done;
    logic [9:0] x_out, y_out;

    int tests = 0;
    int fails = 0;
    int qx[$], qy[$], qrl[$], qlast[$];

    flex_xy_scan #(.NUM_X_BITS(10), .NUM_Y_BITS(10)) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start),
        .x_max(x_max), .y_max(y_max), .x_step(x_step), .out_ready(out_ready),
        .out_valid(out_valid), .x_out(x_out), .y_out(y_out),
        .row_last(row_last), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_scan(input int xm, input int ym, input int st);
        x_max  = 10'(xm);
        y_max  = 10'(ym);
        x_step = 10'(st);
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Runs the scan until done; records accepted beats, held-value violations during stalls,
    // and the cycle gap between the last accepted beat and done.
    task automatic capture(input int mode, input int max_cycles, input int start_at,
                           output int gap, output int stalls, output bit timeout);
        bit         have_stall = 1'b0;
        logic [9:0] sx, sy;
        logic       srl, sl;
        int         last_acc = -1;
        qx.delete(); qy.delete(); qrl.delete(); qlast.delete();
        gap = -1; stalls = 0; timeout = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            if (done === 1'b1) begin
                gap = c - last_acc;
                timeout = 1'b0;
                break;
            end
            if (have_stall) begin
                if (x_out !== sx || y_out !== sy || row_last !== srl || last !== sl) stalls++;
                have_stall = 1'b0;
            end
            out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (c == start_at) begin
                start = 1'b1; x_max = 10'd9; y_max = 10'd3; x_step = 10'd1;
            end else begin
                start = 1'b0;
            end
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    qx.push_back(int'(x_out)); qy.push_back(int'(y_out));
                    qrl.push_back(int'(row_last)); qlast.push_back(int'(last));
                    last_acc = c;
                end else begin
                    have_stall = 1'b1;
                    sx = x_out; sy = y_out; srl = row_last; sl = last;
                end
            end
            tick();
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic check_raster6(input string tag, input int gap, input bit timeout);
        int ex[6]  = '{0, 1, 2, 0, 1, 2};
        int ey[6]  = '{0, 0, 0, 1, 1, 1};
        int erl[6] = '{0, 0, 1, 0, 0, 1};
        int el[6]  = '{0, 0, 0, 0, 0, 1};
        tests++;
        if (timeout !== 1'b0) begin fails++; $display("FAIL %s_timeout: no done pulse seen", tag); end
        tests++;
        if (qx.size() !== 6) begin fails++; $display("FAIL %s_count: got %0d beats, want 6", tag, qx.size()); end
        for (int i = 0; i < 6 && i < qx.size(); i++) begin
            tests++;
            if (qx[i] !== ex[i] || qy[i] !== ey[i] || qrl[i] !== erl[i] || qlast[i] !== el[i]) begin
                fails++;
                $display("FAIL %s_beat%0d: got x=%0d y=%0d rl=%0d last=%0d, want x=%0d y=%0d rl=%0d last=%0d",
                         tag, i, qx[i], qy[i], qrl[i], qlast[i], ex[i], ey[i], erl[i], el[i]);
            end
        end
        tests++;
        if (gap !== 1) begin fails++; $display("FAIL %s_done_gap: got %0d, want 1", tag, gap); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tests++;
        if ({out_valid, x_out, y_out, row_last, last, busy, done} !== 25'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%0b x=%0d y=%0d rl=%0b l=%0b busy=%0b done=%0b, want all 0",
                     out_valid, x_out, y_out, row_last, last, busy, done);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_idle: got v=%0b busy=%0b, want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_basic;
        int gap, stalls; bit to;
        start_scan(2, 1, 1);
        tests++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || x_out !== 10'd0 || y_out !== 10'd0) begin
            fails++; $display("FAIL basic_latency: got v=%0b busy=%0b x=%0d y=%0d, want 1 1 0 0",
                              out_valid, busy, x_out, y_out);
        end
        capture(0, 50, -1, gap, stalls, to);
        check_raster6("basic", gap, to);
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL basic_done_state: got busy=%0b v=%0b, want 0 0", busy, out_valid);
        end
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL basic_done_width: got done=%0b busy=%0b, want 0 0", done, busy);
        end
    endtask

    task automatic test_stride;
        int gap, stalls; bit to;
        int ex[3]  = '{0, 2, 4};
        int erl[3] = '{0, 0, 1};
        for (int pass = 0; pass < 2; pass++) begin
            start_scan(pass == 0 ? 4 : 5, 0, 2);
            capture(0, 50, -1, gap, stalls, to);
            tests++;
            if (to || qx.size() !== 3) begin
                fails++; $display("FAIL stride%0d_count: got %0d beats (timeout=%0b), want 3", pass, qx.size(), to);
            end
            for (int i = 0; i < 3 && i < qx.size(); i++) begin
                tests++;
                if (qx[i] !== ex[i] || qy[i] !== 0 || qrl[i] !== erl[i] || qlast[i] !== erl[i]) begin
                    fails++;
                    $display("FAIL stride%0d_beat%0d: got x=%0d y=%0d rl=%0d last=%0d, want x=%0d y=0 rl=%0d last=%0d",
                             pass, i, qx[i], qy[i], qrl[i], qlast[i], ex[i], erl[i], erl[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        int gap, stalls; bit to;
        start_scan(2, 1, 1);
        capture(1, 100, -1, gap, stalls, to);
        check_raster6("bp", gap, to);
        tests++;
        if (stalls !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes during stalls, want 0", stalls); end
        tick();
    endtask

    task automatic test_abort;
        int gap, stalls; bit to;
        bit saw_done = 1'b0;
        start_scan(2, 1, 1);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || x_out !== 10'd0 || y_out !== 10'd0 || done !== 1'b0) begin
            fails++; $display("FAIL abort_outputs: got v=%0b busy=%0b x=%0d y=%0d done=%0b, want all 0",
                              out_valid, busy, x_out, y_out, done);
        end
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        tests++;
        if (saw_done !== 1'b0) begin fails++; $display("FAIL abort_no_done: got done pulse, want none"); end
        // start together with clear must be ignored
        clear = 1'b1;
        start_scan(2, 1, 1);
        clear = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL abort_start_ignored: got v=%0b busy=%0b, want 0 0", out_valid, busy);
        end
        start_scan(2, 1, 1);
        capture(0, 50, -1, gap, stalls, to);
        check_raster6("abort_rescan", gap, to);
        tick();
    endtask

    task automatic test_overflow;
        int gap, stalls; bit to;
        int bad = 0;
        start_scan(1023, 0, 3);
        capture(0, 1000, -1, gap, stalls, to);
        tests++;
        if (to || qx.size() !== 342) begin
            fails++; $display("FAIL ovf_count: got %0d beats (timeout=%0b), want 342", qx.size(), to);
        end
        for (int i = 0; i < qx.size(); i++) begin
            if (qx[i] !== 3 * i || qy[i] !== 0 || qrl[i] !== int'(i == 341) || qlast[i] !== int'(i == 341)) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL ovf_beats: got %0d wrong beats, want 0", bad); end
        tests++;
        if (qx.size() == 0 || qx[qx.size()-1] !== 1023 || qlast[qlast.size()-1] !== 1) begin
            fails++; $display("FAIL ovf_final: final beat not x=1023 with last=1");
        end
        tick();
        start_scan(2, 0, 0);
        capture(0, 50, -1, gap, stalls, to);
        tests++;
        if (to || qx.size() !== 3 || qx[0] !== 0 || qx[1] !== 1 || qx[2] !== 2 || qlast[2] !== 1) begin
            fails++; $display("FAIL zero_step: got %0d beats (timeout=%0b), want x 0,1,2 with last on 2", qx.size(), to);
        end
        tick();
    endtask

    task automatic test_start_ignore;
        int gap, stalls; bit to;
        start_scan(2, 1, 1);
        capture(0, 50, 2, gap, stalls, to);
        check_raster6("start_mid", gap, to);
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL start_in_done: got v=%0b busy=%0b, want 0 0", out_valid, busy);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL start_in_done_late: got v=%0b, want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        int gap, stalls; bit to;
        for (int pass = 0; pass < 2; pass++) begin
            start_scan(0, 0, 1);
            capture(0, 20, -1, gap, stalls, to);
            tests++;
            if (to || qx.size() !== 1 || qx[0] !== 0 || qy[0] !== 0 || qrl[0] !== 1 || qlast[0] !== 1 || gap !== 1) begin
                fails++; $display("FAIL b2b%0d_single: got %0d beats (timeout=%0b gap=%0d), want one (0,0) rl=1 last=1",
                                  pass, qx.size(), to, gap);
            end
            tick();
        end
    endtask

    task automatic test_rst_mid;
        start_scan(2, 1, 1);
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({out_valid, x_out, y_out, row_last, last, busy, done} !== 25'd0) begin
            fails++; $display("FAIL rst_mid: got v=%0b x=%0d y=%0d rl=%0b l=%0b busy=%0b done=%0b, want all 0",
                              out_valid, x_out, y_out, row_last, last, busy, done);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_mid_idle: got v=%0b busy=%0b, want 0 0", out_valid, busy);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; start = 1'b0; out_ready = 1'b0;
        x_max = '0; y_max = '0; x_step = '0;
        tick();
        test_reset();
        test_basic();
        test_stride();
        test_backpressure();
        test_abort();
        test_overflow();
        test_start_ignore();
        test_back_to_back();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/flex_xy_scan.md
Name: flex_xy_scan

Overview:
- Parametrised 2-D successor to the single-axis flex counter. Generates a raster of (x, y) work coordinates over a programmable region with a programmable horizontal stride.
- Sits in the Work Dispatcher between the job-setup logic (start, region bounds) and the downstream work queue (valid/ready consumer).
- Adds over the single-axis counter: second axis, stride, start/done control, backpressure, abort, and row-end/last markers.

Parameters:
NUM_X_BITS, 10, width of x coordinate, x_max and x_step
NUM_Y_BITS, 10, width of y coordinate and y_max

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
clear  input  1  synchronous abort: return to IDLE with no done pulse
start  input  1  begin a scan (sampled only in IDLE)
x_max  input  NUM_X_BITS  last permissible x (inclusive), latched on start
y_max  input  NUM_Y_BITS  last row index (inclusive), latched on start
x_step  input  NUM_X_BITS  horizontal stride, latched on start; 0 treated as 1
out_ready  input  1  consumer accepts the current coordinate
out_valid  output  1  x_out/y_out hold a valid coordinate
x_out  output  NUM_X_BITS  current x
y_out  output  NUM_Y_BITS  current y
row_last  output  1  current beat is the last x of its row
last  output  1  current beat is the final coordinate of the scan
busy  output  1  high in SCAN
done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- rst (highest priority): state=IDLE; out_valid, x_out, y_out, row_last, last, busy, done all 0; latched bounds=0.
- clear (priority below rst, above all else): identical effect to rst on state and outputs. done is not pulsed. A start in the same cycle is ignored.
- FSM states: IDLE, SCAN, DONE.
- IDLE: on start=1, latch x_max, y_max and x_step (0 becomes 1); x_out=0, y_out=0; enter SCAN next cycle with out_valid=1. Latency: start cycle N -> first valid beat at cycle N+1.
- SCAN: out_valid=1, busy=1. A beat transfers on the clk edge where out_valid && out_ready.
  - While out_ready=0, x_out, y_out, row_last and last hold stable.
  - start is ignored.
  - Input bounds may change freely; only the latched copies are used.
- Stride arithmetic: nx = x_out + step, computed NUM_X_BITS+1 wide so there is no wrap.
  - row_last = (nx > x_max_latched), combinational from current state.
  - last = row_last && (y_out == y_max_latched).
- On transfer:
  - If !row_last: x_out <= nx[NUM_X_BITS-1:0].
  - Else if !last: x_out <= 0, y_out <= y_out+1.
  - Else: state <= DONE, out_valid <= 0, x_out/y_out <= 0.
- x restarts at 0 every row. The last x of a row is the largest k*step <= x_max.
- Total beats = (floor(x_max/step)+1) * (y_max+1).
- DONE: lasts exactly one cycle with done=1, busy=0, out_valid=0, then IDLE. start during DONE is ignored.
- Back-to-back scans: start in the first IDLE cycle after DONE is accepted.
- x_max=0 or y_max=0 are legal (single column / single row). x_max equal to all-ones with any step must terminate correctly via the extra bit.

Test Plan:
- Basic raster: x_max=2, y_max=1, step=1, out_ready=1 -> 6 beats (0,0)(1,0)(2,0)(0,1)(1,1)(2,1). row_last on x=2 beats; last only on (2,1). done pulses one cycle after that beat, then busy=0.
- Stride: x_max=4, y_max=0, step=2 -> x 0,2,4 with last on 4. Repeat with x_max=5, step=2 -> x 0,2,4; row_last on 4.
- Backpressure: basic raster with out_ready toggled 1,0,0,1,... -> same 6-beat sequence, coordinates stable across stalls, no duplicates or skips, done only after the 6th accepted beat.
- Abort: clear asserted after 3rd accepted beat -> next cycle out_valid=0, busy=0, x_out=y_out=0. No done pulse. A subsequent start scans from (0,0).
- Overflow/zero-step: NUM_X_BITS=10, x_max=1023, y_max=0, step=3 -> 342 beats ending at x=1023 with last=1. step=0, x_max=2 -> behaves as step=1 (3 beats).
- Start handling and reset: start pulsed mid-SCAN and during DONE -> ignored, sequence unaffected. rst mid-SCAN -> all outputs 0, IDLE next cycle. x_max=0, y_max=0 -> single beat (0,0) with row_last=last=1.
